wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, width of write-back data.
REQ-002 Parameter: ADDR_W, 5, width of register address (32 registers).
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 alu_valid  input  1  ALU write-back request.
REQ-007 alu_addr  input  ADDR_W  ALU destination register.
REQ-008 alu_data  input  DATA_W  ALU result.
REQ-009 alu_ready  output  1  ALU request accepted this cycle.
REQ-010 lsu_valid  input  1  load-unit write-back request.
REQ-011 lsu_addr  input  ADDR_W  load destination register.
REQ-012 lsu_data  input  DATA_W  load data.
REQ-013 lsu_ready  output  1  load request accepted this cycle.
REQ-014 issue_valid  input  1  an instruction with a destination is issuing.
REQ-015 issue_rd  input  ADDR_W  destination of the issuing instruction.
REQ-016 rs1_addr, rs2_addr  input  ADDR_W each  source registers to check.
REQ-017 rs1_busy, rs2_busy  output  1 each  source has a pending write.
REQ-018 rd_we  output  1  register-file write enable.
REQ-019 rd_addr  output  ADDR_W  register-file write address.
REQ-020 rd_wdata  output  DATA_W  register-file write data.

Function
REQ-021 Arbitration SHALL be round-robin over {ALU=0, LSU=1} with a 1-bit last-grant pointer.
REQ-022 Both valid: grant the requester NOT equal to the pointer; one valid: grant it; none: no grant.
REQ-023 alu_ready/lsu_ready SHALL be combinational, equal to the grant; never both 1 in one cycle.
REQ-024 Transfer = valid && ready; requesters SHALL hold valid/addr/data stable until transfer (bench checks, block does not).
REQ-025 Pointer SHALL update to the granted requester only on a transfer.
REQ-026 On transfer with addr != 0: next cycle rd_we=1, rd_addr/rd_wdata = granted addr/data (latency 1 cycle).
REQ-027 Transfer with addr == 0: accepted (ready=1), rd_we=0 next cycle, scoreboard unchanged.
REQ-028 No transfer: rd_we=0 next cycle; rd_addr/rd_wdata hold previous values.
REQ-029 Scoreboard: 32-bit busy vector; issue_valid with issue_rd != 0 SHALL set busy[issue_rd] at next edge.
REQ-030 Transfer to addr N SHALL clear busy[N] at next edge.
REQ-031 Simultaneous set and clear of same N: set wins (busy[N]=1).
REQ-032 busy[0] SHALL always read 0; issue_rd == 0 ignored.
REQ-033 rs1_busy = busy[rs1_addr], rs2_busy = busy[rs2_addr], combinational from registered vector (no same-cycle bypass of set/clear).

Reset
REQ-034 While rst=1: alu_ready=0, lsu_ready=0, no transfer occurs, issue ignored.
REQ-035 After reset edge: rd_we=0, rd_addr=0, rd_wdata=0, busy=all 0, pointer=1 (ALU wins first contention).
REQ-036 Reset asserted mid-stream SHALL discard any in-flight request; requester must re-present after rst deasserts.

Verification
REQ-037 After reset, alu_valid=1 addr=5 data=0xDEADBEEF -> alu_ready=1 same cycle; next cycle rd_we=1, rd_addr=5, rd_wdata=0xDEADBEEF.
REQ-038 Both valid continuously (ALU addr 3, LSU addr 4) for 4 cycles -> grants ALU,LSU,ALU,LSU; rd_addr sequence 3,4,3,4.
REQ-039 issue_valid=1 issue_rd=7; next cycle rs1_addr=7 -> rs1_busy=1; LSU writes 7 -> rs1_busy=0 cycle after transfer.
REQ-040 Same cycle: issue_rd=9 and ALU transfer to 9 with busy[9]=1 -> busy[9] remains 1.
REQ-041 LSU write to addr 0 data 0x1234 -> lsu_ready=1, rd_we=0 next cycle; issue_rd=0 -> rs1_busy(rs1_addr=0)=0.
REQ-042 busy[2]=1, ALU valid, assert rst one cycle -> alu_ready=0 that cycle; after: rd_we=0, busy[2]=0, next contention grants ALU.

Source files
------------

// File: rtl/wb_arbiter.sv
// Write-back arbiter: round-robin between ALU and load unit onto one register-file
// write port, plus a pending-write scoreboard for source-operand hazard checks.
module wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              lsu_valid,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_data,
  output logic              lsu_ready,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              rd_we,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_wdata
);

  localparam int NREG = 1 << ADDR_W;

  // Pointer holds the last granted requester: 0 = ALU, 1 = LSU.
  logic              ptr;
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_next;
  logic              grant_alu;
  logic              grant_lsu;
  logic              xfer;
  logic              wr;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  always_comb begin
    grant_alu = 1'b0;
    grant_lsu = 1'b0;
    if (!rst) begin
      if (alu_valid && lsu_valid) begin
        grant_alu = ptr;
        grant_lsu = !ptr;
      end else begin
        grant_alu = alu_valid;
        grant_lsu = lsu_valid;
      end
    end
  end

  assign alu_ready = grant_alu;
  assign lsu_ready = grant_lsu;
  assign xfer      = grant_alu || grant_lsu;
  assign win_addr  = grant_lsu ? lsu_addr : alu_addr;
  assign win_data  = grant_lsu ? lsu_data : alu_data;
  assign wr        = xfer && (win_addr != '0);

  // Set is applied after clear so a same-cycle issue to the same register wins.
  always_comb begin
    busy_next = busy;
    if (wr) busy_next[win_addr] = 1'b0;
    if (issue_valid && (issue_rd != '0)) busy_next[issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= 1'b1;
      busy     <= '0;
      rd_we    <= 1'b0;
      rd_addr  <= '0;
      rd_wdata <= '0;
    end else begin
      rd_we <= wr;
      if (wr) begin
        rd_addr  <= win_addr;
        rd_wdata <= win_data;
      end
      if (xfer) ptr <= grant_lsu;
      busy <= busy_next;
    end
  end

  assign rs1_busy = busy[rs1_addr];
  assign rs2_busy = busy[rs2_addr];

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios then randomized traffic,
// checked against a behavioural model with a write-back scoreboard queue.
module tb_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        lsu_valid;
  logic [4:0]  lsu_addr;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        rd_we;
  logic [4:0]  rd_addr;
  logic [31:0] rd_wdata;

  wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_addr(lsu_addr), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rd_we(rd_we), .rd_addr(rd_addr), .rd_wdata(rd_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected register-file port state one cycle after each stimulus cycle.
  typedef struct packed {
    logic        we;
    logic        known;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t expQ[$];

  int errors = 0;
  int checks = 0;

  // Reference model: pending-write set, last winner, and last written port value.
  bit          mBusy[32];
  int          mLast;
  logic [4:0]  mAddr;
  logic [31:0] mData;
  logic        mKnown;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives one cycle of inputs, checks the combinational outputs against the model,
  // advances the model and queues the expected write-back for the monitor.
  task automatic applyStimulus(
    input logic r, input logic av, input logic [4:0] aa, input logic [31:0] ad,
    input logic lv, input logic [4:0] la, input logic [31:0] ld,
    input logic iv, input logic [4:0] ir, input logic [4:0] r1, input logic [4:0] r2,
    output logic ga, output logic gl);
    logic        xfer;
    logic [4:0]  wa;
    logic [31:0] wd;
    exp_t        e;
    @(negedge clk);
    rst = r; alu_valid = av; alu_addr = aa; alu_data = ad;
    lsu_valid = lv; lsu_addr = la; lsu_data = ld;
    issue_valid = iv; issue_rd = ir; rs1_addr = r1; rs2_addr = r2;
    #1;
    if (r) begin
      ga = 1'b0; gl = 1'b0;
    end else if (av && lv) begin
      ga = (mLast == 1);
      gl = !ga;
    end else begin
      ga = av; gl = lv;
    end
    checkOutput("alu_ready", 32'(alu_ready), 32'(ga));
    checkOutput("lsu_ready", 32'(lsu_ready), 32'(gl));
    if (!r) begin
      checkOutput("rs1_busy", 32'(rs1_busy), 32'(mBusy[r1]));
      checkOutput("rs2_busy", 32'(rs2_busy), 32'(mBusy[r2]));
    end
    if (r) begin
      foreach (mBusy[i]) mBusy[i] = 1'b0;
      mLast = 1; mAddr = '0; mData = '0; mKnown = 1'b1;
      e.we = 1'b0;
    end else begin
      xfer = ga || gl;
      wa = gl ? la : aa;
      wd = gl ? ld : ad;
      e.we = xfer && (wa != 0);
      if (xfer) mLast = gl ? 1 : 0;
      if (e.we) begin
        mAddr = wa; mData = wd; mKnown = 1'b1;
        mBusy[wa] = 1'b0;
      end else if (xfer) begin
        mKnown = 1'b0;
      end
      if (iv && ir != 0) mBusy[ir] = 1'b1;
    end
    e.known = mKnown; e.addr = mAddr; e.data = mData;
    expQ.push_back(e);
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    logic ga, gl;
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, r1, r2, ga, gl);
  endtask

  task automatic doReset();
    logic ga, gl;
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, ga, gl);
  endtask

  // Monitor: after every edge, compare the registered write port with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("rd_we", 32'(rd_we), 32'(e.we));
        if (e.known) begin
          checkOutput("rd_addr", 32'(rd_addr), 32'(e.addr));
          checkOutput("rd_wdata", rd_wdata, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        ga, gl;
    logic        pendA, pendL;
    logic [4:0]  pa, pl;
    logic [31:0] da, dl;
    int          w;

    rst = 1'b1; alu_valid = 0; alu_addr = 0; alu_data = 0;
    lsu_valid = 0; lsu_addr = 0; lsu_data = 0;
    issue_valid = 0; issue_rd = 0; rs1_addr = 0; rs2_addr = 0;
    foreach (mBusy[i]) mBusy[i] = 1'b0;
    mLast = 1; mAddr = '0; mData = '0; mKnown = 1'b0;

    doReset();
    doReset();

    // Single ALU write after reset.
    applyStimulus(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, ga, gl);
    checkOutput("req037_alu_ready", 32'(alu_ready), 32'd1);
    idle(5'd0, 5'd0);
    checkOutput("req037_rd_we", 32'(rd_we), 32'd1);
    checkOutput("req037_rd_addr", 32'(rd_addr), 32'd5);
    checkOutput("req037_rd_wdata", rd_wdata, 32'hDEADBEEF);

    // Continuous contention alternates starting with ALU.
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 5'd3, 32'h3333, 1'b1, 5'd4, 32'h4444, 1'b0, 5'd0, 5'd0, 5'd0, ga, gl);
      checkOutput("req038_alu_grant", 32'(alu_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    idle(5'd0, 5'd0);

    // Issue marks register 7 busy, LSU write clears it.
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd0, 5'd0, ga, gl);
    idle(5'd7, 5'd0);
    checkOutput("req039_busy_set", 32'(rs1_busy), 32'd1);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 5'd7, 5'd0, ga, gl);
    idle(5'd7, 5'd0);
    checkOutput("req039_busy_clr", 32'(rs1_busy), 32'd0);

    // Same-cycle set and clear of register 9: set wins.
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd0, 5'd0, ga, gl);
    applyStimulus(1'b0, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd0, ga, gl);
    idle(5'd9, 5'd0);
    checkOutput("req040_set_wins", 32'(rs1_busy), 32'd1);

    // Writes and issues to register 0 are harmless.
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 5'd0, 5'd0, ga, gl);
    checkOutput("req041_lsu_ready", 32'(lsu_ready), 32'd1);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 5'd0, ga, gl);
    checkOutput("req041_rd_we", 32'(rd_we), 32'd0);
    idle(5'd0, 5'd0);
    checkOutput("req041_busy0", 32'(rs1_busy), 32'd0);

    // Reset mid-stream drops the pending request and the scoreboard.
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h66, 1'b1, 5'd2, 5'd0, 5'd0, ga, gl);
    applyStimulus(1'b1, 1'b1, 5'd6, 32'h600D, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd2, ga, gl);
    checkOutput("req042_alu_ready_rst", 32'(alu_ready), 32'd0);
    idle(5'd0, 5'd2);
    checkOutput("req042_busy2", 32'(rs2_busy), 32'd0);
    checkOutput("req042_rd_we", 32'(rd_we), 32'd0);
    applyStimulus(1'b0, 1'b1, 5'd10, 32'hA, 1'b1, 5'd11, 32'hB, 1'b0, 5'd0, 5'd0, 5'd0, ga, gl);
    checkOutput("req042_alu_first", 32'(alu_ready), 32'd1);

    // Random traffic: requesters hold their request until it is accepted.
    pendA = 0; pendL = 0; pa = 0; pl = 0; da = 0; dl = 0;
    for (int c = 0; c < 400; c++) begin
      logic r, iv;
      r = ($urandom_range(0, 49) == 0);
      if (!pendA && $urandom_range(0, 2) != 0) begin
        pendA = 1; pa = 5'($urandom_range(0, 31)); da = $urandom;
      end
      if (!pendL && $urandom_range(0, 2) != 0) begin
        pendL = 1; pl = 5'($urandom_range(0, 31)); dl = $urandom;
      end
      iv = ($urandom_range(0, 1) == 1);
      applyStimulus(r, pendA, pa, da, pendL, pl, dl, iv, 5'($urandom_range(0, 31)),
                    5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), ga, gl);
      if (r) begin
        pendA = 0; pendL = 0;
      end else begin
        if (ga) pendA = 0;
        if (gl) pendL = 0;
      end
    end
    idle(5'd0, 5'd0);

    w = 0;
    while (expQ.size() > 0 && w < 10) begin
      @(posedge clk);
      #2;
      w++;
    end
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", expQ.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
